// File: rtl/hdmi_audio_conditioner.sv
// Audio front end for the HDMI encoder: fractional sample-clock generator,
// per-sample PCM capture, ramped gain with mute, round-down and saturate with sticky clip flags.
module hdmi_audio_conditioner #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 2,
  parameter int GAIN_BITS = 4,
  parameter int ACC_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ACC_WIDTH-1:0]          rate_inc,
  input  logic [CHANNELS*IN_WIDTH-1:0]  audio_in,
  input  logic [GAIN_BITS-1:0]          volume,
  input  logic                          mute,
  input  logic                          clip_clr,
  output logic                          clk_audio,
  output logic                          sample_stb,
  output logic [CHANNELS*OUT_WIDTH-1:0] audio_out,
  output logic [GAIN_BITS-1:0]          gain_cur,
  output logic [CHANNELS-1:0]           clip
);

  // Product width: signed sample times a zero-extended unsigned gain code.
  localparam int PW = IN_WIDTH + GAIN_BITS + 1;
  localparam int SH = GAIN_BITS - 1 + SHIFT;
  localparam logic [GAIN_BITS-1:0] GAIN_ONE = 1;
  localparam logic signed [PW-1:0] SAT_HI = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0]         acc;
  logic [ACC_WIDTH:0]           acc_sum;
  logic                         tick;
  logic                         capture;
  logic                         cap_d1;
  logic                         cap_d2;
  logic [CHANNELS*IN_WIDTH-1:0] snap;
  logic [GAIN_BITS-1:0]         gain_tgt;
  logic [GAIN_BITS-1:0]         gain_nxt;
  logic [CHANNELS-1:0]          clip_set;

  assign acc_sum = {1'b0, acc} + {1'b0, rate_inc};
  assign tick    = acc_sum[ACC_WIDTH];
  // A tick while clk_audio is high is its falling transition: the capture point.
  assign capture = tick & clk_audio;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      clk_audio  <= 1'b0;
      sample_stb <= 1'b0;
    end else begin
      acc        <= acc_sum[ACC_WIDTH-1:0];
      sample_stb <= tick & ~clk_audio;
      if (tick)
        clk_audio <= ~clk_audio;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap   <= '0;
      cap_d1 <= 1'b0;
      cap_d2 <= 1'b0;
    end else begin
      cap_d1 <= capture;
      cap_d2 <= cap_d1;
      if (capture)
        snap <= audio_in;
    end
  end

  always_comb begin
    gain_tgt = mute ? '0 : volume;
    gain_nxt = gain_cur;
    if (gain_cur < gain_tgt)
      gain_nxt = gain_cur + GAIN_ONE;
    else if (gain_cur > gain_tgt)
      gain_nxt = gain_cur - GAIN_ONE;
  end

  // The product stage consumes the stepped gain in the same cycle it is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gain_cur <= '0;
    else if (cap_d1)
      gain_cur <= gain_nxt;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic signed [IN_WIDTH-1:0]  s_in;
    logic signed [PW-1:0]        s_ext;
    logic signed [PW-1:0]        g_ext;
    logic signed [PW-1:0]        prod_c;
    logic signed [PW-1:0]        prod_q;
    logic signed [PW-1:0]        y;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [OUT_WIDTH-1:0] y_sat;
    logic signed [OUT_WIDTH-1:0] out_q;

    assign s_in   = snap[i*IN_WIDTH +: IN_WIDTH];
    assign s_ext  = PW'(s_in);
    assign g_ext  = PW'({1'b0, gain_nxt});
    assign prod_c = s_ext * g_ext;
    assign y      = prod_q >>> SH;
    assign sat_hi = y > SAT_HI;
    assign sat_lo = y < SAT_LO;

    always_comb begin
      y_sat = y[OUT_WIDTH-1:0];
      if (sat_hi)
        y_sat = SAT_HI[OUT_WIDTH-1:0];
      else if (sat_lo)
        y_sat = SAT_LO[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prod_q <= '0;
        out_q  <= '0;
      end else begin
        if (cap_d1)
          prod_q <= prod_c;
        if (cap_d2)
          out_q <= y_sat;
      end
    end

    assign clip_set[i] = cap_d2 & (sat_hi | sat_lo);
    assign audio_out[i*OUT_WIDTH +: OUT_WIDTH] = out_q;
  end

  // A new saturation in the clearing cycle survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      clip <= '0;
    else
      clip <= (clip & ~{CHANNELS{clip_clr}}) | clip_set;
  end

endmodule

// File: tb/tb_hdmi_audio_conditioner.sv
// Directed bench for hdmi_audio_conditioner: rate, ramp, saturation, clip clear race,
// mute and asynchronous reset, each with hand-computed expected values.
module tb_hdmi_audio_conditioner;

  localparam logic [23:0] RATE_FAST = 24'd2097152;  // tick every 8 clk

  logic        clk;
  logic        reset;
  logic [23:0] rate_inc;
  logic [35:0] audio_in;
  logic [3:0]  volume;
  logic        mute;
  logic        clip_clr;
  logic        clk_audio;
  logic        sample_stb;
  logic [31:0] audio_out;
  logic [3:0]  gain_cur;
  logic [1:0]  clip;

  logic signed [15:0] out0;
  logic signed [15:0] out1;
  assign out0 = audio_out[15:0];
  assign out1 = audio_out[31:16];

  int checks = 0;
  int errors = 0;

  hdmi_audio_conditioner dut (
    .clk        (clk),
    .reset      (reset),
    .rate_inc   (rate_inc),
    .audio_in   (audio_in),
    .volume     (volume),
    .mute       (mute),
    .clip_clr   (clip_clr),
    .clk_audio  (clk_audio),
    .sample_stb (sample_stb),
    .audio_out  (audio_out),
    .gain_cur   (gain_cur),
    .clip       (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_audio(input int c0, input int c1);
    audio_in = {18'(c1), 18'(c0)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge that first sees clk_audio settle at 'level' after being the opposite.
  task automatic wait_edge(input logic level);
    logic prev;
    prev = clk_audio;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev == ~level && clk_audio == level) return;
      prev = clk_audio;
    end
    checks++;
    errors++;
    $display("FAIL edge_timeout: clk_audio never reached %0b within 400 cycles", level);
  endtask

  task automatic wait_out();
    wait_edge(1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_sample(input string name, input int g, input int e0, input int e1);
    checks++;
    if (gain_cur !== 4'(g) || out0 !== 16'(e0) || out1 !== 16'(e1)) begin
      errors++;
      $display("FAIL %s: gain=%0d ch0=%0d ch1=%0d, expected gain=%0d ch0=%0d ch1=%0d",
               name, gain_cur, out0, out1, g, e0, e1);
    end
  endtask

  task automatic test_reset();
    rate_inc = RATE_FAST;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (clk_audio !== 1'b0 || sample_stb !== 1'b0 || gain_cur !== 4'd0 ||
        audio_out !== 32'd0 || clip !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: clk_audio=%0b stb=%0b gain=%0d out=%h clip=%b, expected all 0",
               clk_audio, sample_stb, gain_cur, audio_out, clip);
    end
    reset = 1'b0;
  endtask

  task automatic test_rate();
    int toggles, pulses, width_err, misplaced;
    logic prev_ca, prev_stb;
    rate_inc = 24'd51130;
    do_reset();
    toggles = 0; pulses = 0; width_err = 0; misplaced = 0;
    prev_ca = clk_audio;
    prev_stb = sample_stb;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (clk_audio != prev_ca) toggles++;
      if (sample_stb) begin
        pulses++;
        if (prev_stb) width_err++;
        if (!(clk_audio && !prev_ca)) misplaced++;
      end
      prev_ca = clk_audio;
      prev_stb = sample_stb;
    end
    checks++;
    if (toggles < 181 || toggles > 183) begin
      errors++;
      $display("FAIL rate_toggles: got %0d, expected 182 +/-1", toggles);
    end
    checks++;
    if (pulses < 90 || pulses > 92) begin
      errors++;
      $display("FAIL rate_pulses: got %0d, expected 91 +/-1", pulses);
    end
    checks++;
    if (width_err != 0 || misplaced != 0) begin
      errors++;
      $display("FAIL stb_shape: wide=%0d misplaced=%0d, expected 0 and 0", width_err, misplaced);
    end
    checks++;
    if (gain_cur !== 4'd8) begin
      errors++;
      $display("FAIL rate_gain_settled: gain=%0d, expected 8", gain_cur);
    end
    rate_inc = 24'd0;
    toggles = 0; pulses = 0;
    prev_ca = clk_audio;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (clk_audio != prev_ca) toggles++;
      if (sample_stb) pulses++;
      prev_ca = clk_audio;
    end
    checks++;
    if (toggles != 0 || pulses != 0 || gain_cur !== 4'd8) begin
      errors++;
      $display("FAIL rate_zero: toggles=%0d pulses=%0d gain=%0d, expected 0 0 8",
               toggles, pulses, gain_cur);
    end
  endtask

  task automatic test_ramp();
    volume = 4'd8;
    mute = 1'b0;
    set_audio(4096, -2048);
    rate_inc = RATE_FAST;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      wait_out();
      check_sample("ramp_up", k, 128 * k, -64 * k);
    end
    volume = 4'd4;
    for (int g = 7; g >= 4; g--) begin
      wait_out();
      check_sample("ramp_down", g, 128 * g, -64 * g);
    end
    wait_out();
    check_sample("ramp_hold", 4, 512, -256);
  endtask

  task automatic test_saturation();
    volume = 4'd15;
    set_audio(131071, -131072);
    repeat (11) wait_out();
    check_sample("sat_full", 15, 32767, -32768);
    checks++;
    if (clip !== 2'b11) begin
      errors++;
      $display("FAIL sat_clip: clip=%b, expected 11", clip);
    end
    set_audio(100, -131072);
    wait_out();
    check_sample("sat_small", 15, 46, -32768);
    checks++;
    if (clip !== 2'b11) begin
      errors++;
      $display("FAIL sat_clip_sticky: clip=%b, expected 11", clip);
    end
  endtask

  task automatic test_clip_race();
    wait_edge(1'b0);
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    checks++;
    if (clip !== 2'b10 || out0 !== 16'sd46) begin
      errors++;
      $display("FAIL clip_race: clip=%b ch0=%0d, expected 10 and 46", clip, out0);
    end
    set_audio(100, 100);
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    checks++;
    if (clip !== 2'b00) begin
      errors++;
      $display("FAIL clip_clear: clip=%b, expected 00", clip);
    end
    wait_out();
    check_sample("clip_in_range", 15, 46, 46);
    checks++;
    if (clip !== 2'b00) begin
      errors++;
      $display("FAIL clip_stay_clear: clip=%b, expected 00", clip);
    end
  endtask

  task automatic test_mute();
    volume = 4'd8;
    set_audio(4096, 0);
    do_reset();
    repeat (5) wait_out();
    check_sample("mute_pre", 5, 640, 0);
    mute = 1'b1;
    for (int g = 4; g >= 0; g--) begin
      wait_out();
      check_sample("mute_down", g, 128 * g, 0);
    end
    mute = 1'b0;
    for (int g = 1; g <= 8; g++) begin
      wait_out();
      check_sample("unmute_up", g, 128 * g, 0);
    end
  endtask

  task automatic test_async_reset();
    volume = 4'd12;
    repeat (2) wait_out();
    check_sample("pre_reset", 10, 1280, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (clk_audio !== 1'b0 || sample_stb !== 1'b0 || gain_cur !== 4'd0 ||
        audio_out !== 32'd0 || clip !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: clk_audio=%0b stb=%0b gain=%0d out=%h clip=%b, expected all 0",
               clk_audio, sample_stb, gain_cur, audio_out, clip);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_edge(1'b1);
    check_sample("post_reset_first_tick", 0, 0, 0);
    wait_out();
    check_sample("post_reset_first_sample", 1, 128, 0);
  endtask

  initial begin
    reset = 1'b1;
    rate_inc = 24'd0;
    audio_in = '0;
    volume = 4'd8;
    mute = 1'b0;
    clip_clr = 1'b0;
    test_reset();
    test_rate();
    test_ramp();
    test_saturation();
    test_clip_race();
    test_mute();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
